// File: rtl/life_pkg.sv
// Shared definitions for the Game-of-Life arena stepper.
`default_nettype none

package life_pkg;

  localparam int ROW_ADDR_W = 10;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_PRIME0 = 3'd1,
    S_PRIME1 = 3'd2,
    S_PRIME2 = 3'd3,
    S_FETCH  = 3'd4,
    S_LATCH  = 3'd5,
    S_WRITE  = 3'd6,
    S_DONE   = 3'd7
  } state_t;

endpackage

`default_nettype wire

// File: rtl/life_row_rule.sv
// Combinational Life rule for one row, with horizontal wrap-around.
`default_nettype none

module life_row_rule #(
  parameter int WIDTH = 10
) (
  input  logic [WIDTH-1:0] prev,
  input  logic [WIDTH-1:0] cur,
  input  logic [WIDTH-1:0] next,
  output logic [WIDTH-1:0] new_row
);

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    localparam int L = (i == 0) ? WIDTH - 1 : i - 1;
    localparam int R = (i == WIDTH - 1) ? 0 : i + 1;

    logic [3:0] w_cnt;

    // The cell itself (cur[i]) is excluded from its own neighbour count.
    assign w_cnt = {3'b000, prev[L]} + {3'b000, prev[i]} + {3'b000, prev[R]}
                 + {3'b000, cur[L]}                      + {3'b000, cur[R]}
                 + {3'b000, next[L]} + {3'b000, next[i]} + {3'b000, next[R]};

    assign new_row[i] = (w_cnt == 4'd3) || ((w_cnt == 4'd2) && cur[i]);
  end

endmodule

`default_nettype wire

// File: rtl/life_stepper.sv
// Steps a toroidal Life arena one generation, streaming rows through a
// three-row window over a registered single-port memory.
`default_nettype none

module life_stepper
  import life_pkg::*;
#(
  parameter int WIDTH  = 10,
  parameter int HEIGHT = 10
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic [15:0]           gen_count,
  output logic [ROW_ADDR_W-1:0] mem_row,
  output logic [WIDTH-1:0]      mem_columns_out,
  input  logic [WIDTH-1:0]      mem_columns_in,
  output logic                  mem_write
);

  localparam logic [ROW_ADDR_W-1:0] LAST_ROW = ROW_ADDR_W'(HEIGHT - 1);

  state_t                  state_q, state_d;
  logic [ROW_ADDR_W-1:0]   r_q, r_d;
  logic [WIDTH-1:0]        prev_q, prev_d;
  logic [WIDTH-1:0]        cur_q, cur_d;
  logic [WIDTH-1:0]        next_q, next_d;
  logic [WIDTH-1:0]        row0_q, row0_d;
  logic                    done_q, done_d;
  logic [15:0]             gen_q, gen_d;
  logic [WIDTH-1:0]        new_row;
  logic                    last_row;

  life_row_rule #(.WIDTH(WIDTH)) u_rule (
    .prev    (prev_q),
    .cur     (cur_q),
    .next    (next_q),
    .new_row (new_row)
  );

  assign last_row = (r_q == LAST_ROW);

  always_comb begin
    state_d         = state_q;
    r_d             = r_q;
    prev_d          = prev_q;
    cur_d           = cur_q;
    next_d          = next_q;
    row0_d          = row0_q;
    done_d          = 1'b0;
    gen_d           = gen_q;
    mem_row         = '0;
    mem_write       = 1'b0;
    mem_columns_out = '0;

    case (state_q)
      S_IDLE: begin
        if (start) state_d = S_PRIME0;
      end
      S_PRIME0: begin
        mem_row = LAST_ROW;
        state_d = S_PRIME1;
      end
      S_PRIME1: begin
        mem_row = '0;
        prev_d  = mem_columns_in;
        state_d = S_PRIME2;
      end
      S_PRIME2: begin
        cur_d   = mem_columns_in;
        row0_d  = mem_columns_in;
        r_d     = '0;
        state_d = S_FETCH;
      end
      S_FETCH: begin
        if (!last_row) mem_row = r_q + 1'b1;
        state_d = S_LATCH;
      end
      S_LATCH: begin
        // Row 0 has already been overwritten by now, so wrap uses the saved copy.
        next_d  = last_row ? row0_q : mem_columns_in;
        state_d = S_WRITE;
      end
      S_WRITE: begin
        mem_row         = r_q;
        mem_write       = 1'b1;
        mem_columns_out = new_row;
        if (last_row) begin
          state_d = S_DONE;
        end else begin
          prev_d  = cur_q;
          cur_d   = next_q;
          r_d     = r_q + 1'b1;
          state_d = S_FETCH;
        end
      end
      S_DONE: begin
        done_d  = 1'b1;
        gen_d   = gen_q + 16'd1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      r_q     <= '0;
      prev_q  <= '0;
      cur_q   <= '0;
      next_q  <= '0;
      row0_q  <= '0;
      done_q  <= 1'b0;
      gen_q   <= '0;
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      prev_q  <= prev_d;
      cur_q   <= cur_d;
      next_q  <= next_d;
      row0_q  <= row0_d;
      done_q  <= done_d;
      gen_q   <= gen_d;
    end
  end

  assign busy      = (state_q != S_IDLE) && (state_q != S_DONE);
  assign done      = done_q;
  assign gen_count = gen_q;

endmodule

`default_nettype wire

// File: tb/tb_life_stepper.sv
// Self-checking bench: directed and random arenas against a toroidal Life model.
`default_nettype none

module tb_life_stepper;

  localparam int W = 10;
  localparam int H = 10;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         busy, done, mem_write;
  logic [15:0]  gen_count;
  logic [9:0]   mem_row;
  logic [W-1:0] mem_columns_out;
  logic [W-1:0] mem_columns_in;

  logic [W-1:0] arena [H];
  logic [W-1:0] ld_img [H];
  logic [W-1:0] src_img [H];
  logic [W-1:0] exp_img [H];
  logic         ld = 1'b0;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  life_stepper #(.WIDTH(W), .HEIGHT(H)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .start           (start),
    .busy            (busy),
    .done            (done),
    .gen_count       (gen_count),
    .mem_row         (mem_row),
    .mem_columns_out (mem_columns_out),
    .mem_columns_in  (mem_columns_in),
    .mem_write       (mem_write)
  );

  // Arena memory with registered read; ld is a backdoor preload.
  always @(posedge clk) begin
    if (ld) begin
      for (int i = 0; i < H; i++) arena[i] <= ld_img[i];
    end else if (mem_write && mem_row < H) begin
      arena[mem_row] <= mem_columns_out;
    end
    mem_columns_in <= (mem_row < H) ? arena[mem_row] : '0;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic load_arena();
    @(negedge clk);
    ld = 1'b1;
    @(posedge clk);
    #1 ld = 1'b0;
  endtask

  // Reference: plain toroidal Game of Life over src_img -> exp_img.
  task automatic compute_expected();
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) begin
        int cnt;
        cnt = 0;
        for (int dr = -1; dr <= 1; dr++)
          for (int dc = -1; dc <= 1; dc++)
            if (dr != 0 || dc != 0)
              cnt += int'(src_img[(r + dr + H) % H][(c + dc + W) % W]);
        exp_img[r][c] = (cnt == 3) || (cnt == 2 && src_img[r][c]);
      end
    end
  endtask

  task automatic check_arena(input string tag);
    for (int i = 0; i < H; i++) check($sformatf("%s_row%0d", tag, i), 32'(arena[i]), 32'(exp_img[i]));
  endtask

  task automatic run_step(input string tag, input int hold, input int exp_gen);
    int writes, done_cnt, done_at;
    bit order_ok, busy_ok;
    for (int i = 0; i < H; i++) src_img[i] = arena[i];
    compute_expected();
    writes = 0; done_cnt = 0; done_at = -1; order_ok = 1; busy_ok = 1;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = (hold > 0);
    for (int k = 1; k <= 45; k++) begin
      @(posedge clk);
      #1;
      start = (k < hold);
      if (mem_write) begin
        if (mem_row != 10'(writes)) order_ok = 0;
        writes++;
      end
      if (done) begin
        done_cnt++;
        if (done_at < 0) done_at = k;
      end
      if (busy !== (k >= 1 && k <= 3 * H + 2)) busy_ok = 0;
    end
    start = 1'b0;
    check({tag, "_done_cycle"}, 32'(done_at), 32'(3 + 3 * H + 1));
    check({tag, "_done_pulses"}, 32'(done_cnt), 32'd1);
    check({tag, "_writes"}, 32'(writes), 32'(H));
    check({tag, "_row_order"}, 32'(order_ok), 32'd1);
    check({tag, "_busy"}, 32'(busy_ok), 32'd1);
    check({tag, "_gen_count"}, 32'(gen_count), 32'(exp_gen));
    check_arena(tag);
  endtask

  initial begin
    int gen;
    bit hit;

    for (int i = 0; i < H; i++) ld_img[i] = '0;
    #12;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_gen", 32'(gen_count), 32'd0);
    check("rst_mem_write", 32'(mem_write), 32'd0);
    check("rst_mem_row", 32'(mem_row), 32'd0);
    check("rst_mem_out", 32'(mem_columns_out), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    gen = 0;

    // Blinker: two steps return to the original pattern.
    for (int i = 0; i < H; i++) ld_img[i] = '0;
    ld_img[4] = 10'h010; ld_img[5] = 10'h010; ld_img[6] = 10'h010;
    load_arena();
    run_step("blink1", 0, ++gen);
    check("blink1_row5_literal", 32'(arena[5]), 32'h038);
    check("blink1_row4_literal", 32'(arena[4]), 32'h000);
    run_step("blink2", 0, ++gen);
    check("blink2_row4_literal", 32'(arena[4]), 32'h010);

    // All alive: every cell has 8 neighbours and dies.
    for (int i = 0; i < H; i++) ld_img[i] = 10'h3FF;
    load_arena();
    run_step("full", 0, ++gen);
    check("full_row0_literal", 32'(arena[0]), 32'h000);

    // Corner block spanning both wraps is a still life.
    for (int i = 0; i < H; i++) ld_img[i] = '0;
    ld_img[0] = 10'h201; ld_img[H-1] = 10'h201;
    load_arena();
    run_step("wrap", 0, ++gen);
    check("wrap_row0_literal", 32'(arena[0]), 32'h201);
    check("wrap_row9_literal", 32'(arena[H-1]), 32'h201);

    // start held high while busy must not restart or add steps.
    for (int i = 0; i < H; i++) ld_img[i] = 10'($urandom) & 10'h3FF;
    load_arena();
    run_step("busy_start", 20, ++gen);

    for (int t = 0; t < 3; t++) begin
      for (int i = 0; i < H; i++) ld_img[i] = 10'($urandom);
      load_arena();
      run_step($sformatf("rand%0d", t), 0, ++gen);
    end

    // Reset taken during the write of row 4.
    for (int i = 0; i < H; i++) ld_img[i] = 10'($urandom);
    load_arena();
    for (int i = 0; i < H; i++) src_img[i] = arena[i];
    compute_expected();
    for (int i = 4; i < H; i++) exp_img[i] = src_img[i];
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    hit = 0;
    for (int k = 0; k < 40 && !hit; k++) begin
      if (mem_write && mem_row == 10'd4) hit = 1;
      else begin
        @(posedge clk);
        #1;
      end
    end
    check("mid_rst_reached_row4", 32'(hit), 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_mem_write", 32'(mem_write), 32'd0);
    check("mid_rst_mem_row", 32'(mem_row), 32'd0);
    check("mid_rst_mem_out", 32'(mem_columns_out), 32'd0);
    check("mid_rst_gen", 32'(gen_count), 32'd0);
    check("mid_rst_done", 32'(done), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    check_arena("mid_rst");
    @(negedge clk);
    rst_n = 1'b1;
    run_step("after_rst", 0, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
